// File: rtl/scl180_sparecell_pkg.sv
// Shared types and constants for the spare-cell LO monitor.
// FSM state encoding and synchronizer flush length.
package scl180_sparecell_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    SCAN   = 2'd2,
    REPORT = 2'd3
  } state_e;

  localparam int unsigned SYNC_CYCLES = 2;

endpackage

// File: rtl/scl180_sparecell_monitor_sync2.sv
// Parameterised-width two-flop synchronizer.
// Asynchronous active-high reset clears both stages.
module scl180_sync2 #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/scl180_sparecell_monitor.sv
// Spare-cell tie-low checker: filters each synchronized LO line
// over FILT_LEN samples and reports cells stuck high.
module scl180_sparecell_monitor
  import scl180_sparecell_pkg::*;
#(
  parameter int NUM_CELLS = 16,
  parameter int FILT_LEN  = 4,
  parameter int ERRCNT_W  = 8
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_i,
  input  logic [NUM_CELLS-1:0]           spare_lo,
  input  logic                           scan_start,
  input  logic                           clr_stats,
  output logic                           busy,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [NUM_CELLS-1:0]           fault_map,
  output logic [$clog2(NUM_CELLS+1)-1:0] fault_cnt,
  output logic                           any_fault,
  output logic [ERRCNT_W-1:0]            err_scans
);

  localparam int IDX_W = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
  localparam int SUB_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int CNT_W = $clog2(NUM_CELLS + 1);

  localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(NUM_CELLS - 1);
  localparam logic [SUB_W-1:0]    SUB_LAST  = SUB_W'(FILT_LEN - 1);
  localparam logic [1:0]          SYNC_LAST = 2'(SYNC_CYCLES - 1);
  localparam logic [ERRCNT_W-1:0] ERR_MAX   = '1;

  logic [NUM_CELLS-1:0] lo_sync;

  state_e               state_q;
  logic [1:0]           sync_cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic [SUB_W-1:0]     sub_q;
  logic                 acc_q;
  logic [NUM_CELLS-1:0] stage_q;
  logic                 busy_q;
  logic                 valid_q;
  logic [NUM_CELLS-1:0] map_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 any_q;
  logic [ERRCNT_W-1:0]  err_q;

  logic                 cell_and;
  logic                 last_sample;
  logic [NUM_CELLS-1:0] stage_d;
  logic [CNT_W-1:0]     cnt_d;
  logic                 any_d;
  logic [ERRCNT_W-1:0]  err_d;

  scl180_sync2 #(
    .W (NUM_CELLS)
  ) u_sync (
    .clk_i (wb_clk_i),
    .rst_i (wb_rst_i),
    .d_i   (spare_lo),
    .q_o   (lo_sync)
  );

  // Running AND for the current cell restarts on its first sample.
  always_comb begin
    cell_and = (sub_q == '0) ? lo_sync[idx_q]
                             : (acc_q & lo_sync[idx_q]);
    last_sample = (sub_q == SUB_LAST) && (idx_q == IDX_LAST);
    stage_d = stage_q;
    if (sub_q == SUB_LAST) begin
      stage_d[idx_q] = cell_and;
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      cnt_d = cnt_d + CNT_W'(stage_d[i]);
    end
    any_d = |stage_d;
  end

  // Clear beats a coincident increment.
  always_comb begin
    err_d = err_q;
    if (clr_stats) begin
      err_d = '0;
    end else if (state_q == SCAN && last_sample &&
                 any_d && err_q != ERR_MAX) begin
      err_d = err_q + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      sync_cnt_q <= '0;
      idx_q      <= '0;
      sub_q      <= '0;
      acc_q      <= 1'b0;
      stage_q    <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      map_q      <= '0;
      cnt_q      <= '0;
      any_q      <= 1'b0;
      err_q      <= '0;
    end else begin
      err_q <= err_d;
      unique case (state_q)
        IDLE: begin
          if (scan_start) begin
            state_q    <= SYNC;
            busy_q     <= 1'b1;
            sync_cnt_q <= '0;
            stage_q    <= '0;
          end
        end
        SYNC: begin
          if (sync_cnt_q == SYNC_LAST) begin
            state_q <= SCAN;
            idx_q   <= '0;
            sub_q   <= '0;
          end else begin
            sync_cnt_q <= sync_cnt_q + 2'd1;
          end
        end
        SCAN: begin
          acc_q   <= cell_and;
          stage_q <= stage_d;
          if (sub_q == SUB_LAST) begin
            sub_q <= '0;
            if (idx_q == IDX_LAST) begin
              state_q <= REPORT;
              idx_q   <= '0;
              valid_q <= 1'b1;
              map_q   <= stage_d;
              cnt_q   <= cnt_d;
              any_q   <= any_d;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            sub_q <= sub_q + 1'b1;
          end
        end
        REPORT: begin
          if (res_ready) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign res_valid = valid_q;
  assign fault_map = map_q;
  assign fault_cnt = cnt_q;
  assign any_fault = any_q;
  assign err_scans = err_q;

endmodule
